// File: rtl/switch_response_encoder_if.sv
// switch_response_encoder_if: raw key/switch inputs, game-FSM control and registered response outputs
interface switch_response_encoder_if;
    logic       KEY0_RAW;
    logic [8:0] SW_RAW;
    logic       ARM;
    logic [3:0] TARGET;
    logic       START_PULSE;
    logic [8:0] SW_CLEAN;
    logic       RESP_VALID;
    logic [3:0] RESP_INDEX;
    logic       RESP_HIT;
    logic       RESP_MULTI;
    logic       FALSE_START;

    modport master (
        output KEY0_RAW, SW_RAW, ARM, TARGET,
        input  START_PULSE, SW_CLEAN, RESP_VALID, RESP_INDEX, RESP_HIT, RESP_MULTI, FALSE_START
    );

    modport slave (
        input  KEY0_RAW, SW_RAW, ARM, TARGET,
        output START_PULSE, SW_CLEAN, RESP_VALID, RESP_INDEX, RESP_HIT, RESP_MULTI, FALSE_START
    );
endinterface

// File: rtl/switch_response_encoder.sv
// switch_response_encoder: synchronize/debounce KEY0 and SW[9:1], start pulse, first-flip response capture.
// Optional false-start detection when SWRESP_FALSE_START_EN is defined.
module switch_response_encoder #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                      CLK_10MHZ,
    input  logic                      RST_N,
    switch_response_encoder_if.slave  bus
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // bit 0 carries the active-low key, bits 9:1 the switches
    localparam logic [9:0]      RELEASED = 10'h001;
    localparam logic [1:0]      IDLE     = 2'd0;
    localparam logic [1:0]      ARMED    = 2'd1;
    localparam logic [1:0]      DONE     = 2'd2;

    logic [9:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [9:0]    deb_q, deb_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q [10];
    logic [CW-1:0] cnt_d [10];
    logic          start_q, start_d;
    logic [1:0]    state_q, state_d;
    logic          valid_q, valid_d;
    logic [3:0]    index_q, index_d;
    logic          hit_q, hit_d;
    logic          multi_q, multi_d;
    logic          fs_q, fs_d;
    logic [8:0]    sw_rise;
    logic [3:0]    low_idx;
    logic [3:0]    rise_cnt;

    // two-flop synchronizers followed by per-input debounce counters
    always_comb begin
        sync1_d = {bus.SW_RAW, bus.KEY0_RAW};
        sync2_d = sync1_q;
        prev_d  = deb_q;
        for (int i = 0; i < 10; i++) begin
            deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == CNT_LAST) ? sync2_q[i] : deb_q[i];
            cnt_d[i] = (sync2_q[i] == deb_q[i] || cnt_q[i] == CNT_LAST) ? '0 : cnt_q[i] + 1'b1;
        end
    end

    // edge detection on debounced levels, lowest rising index and rise count
    always_comb begin
        start_d  = prev_q[0] & ~deb_q[0];
        sw_rise  = deb_q[9:1] & ~prev_q[9:1];
        low_idx  = '0;
        rise_cnt = '0;
        for (int i = 8; i >= 0; i--)
            low_idx = sw_rise[i] ? 4'(i + 1) : low_idx;
        for (int i = 0; i < 9; i++)
            rise_cnt = rise_cnt + {3'b000, sw_rise[i]};
    end

    // response FSM: capture the first rising switch while armed, hold until ARM drops
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        index_d = index_q;
        hit_d   = hit_q;
        multi_d = multi_q;
        fs_d    = fs_q;
        case (state_q)
            IDLE: begin
                state_d = bus.ARM ? ARMED : IDLE;
`ifdef SWRESP_FALSE_START_EN
                if (bus.ARM && |deb_q[9:1]) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    index_d = '0;
                    hit_d   = 1'b0;
                    multi_d = 1'b0;
                    fs_d    = 1'b1;
                end
`endif
            end
            ARMED: begin
                if (!bus.ARM) begin
                    state_d = IDLE;
                end else if (|sw_rise) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    index_d = low_idx;
                    multi_d = rise_cnt > 4'd1;
                    // low_idx is 1..9 here, so targets outside 1..9 can never match
                    hit_d   = rise_cnt == 4'd1 && low_idx == bus.TARGET;
                end
            end
            DONE: begin
                if (!bus.ARM) begin
                    state_d = IDLE;
                    index_d = '0;
                    hit_d   = 1'b0;
                    multi_d = 1'b0;
                    fs_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with asynchronous active-low reset to released input levels
    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
            deb_q   <= RELEASED;
            prev_q  <= RELEASED;
            for (int i = 0; i < 10; i++) cnt_q[i] <= '0;
            start_q <= 1'b0;
            state_q <= IDLE;
            valid_q <= 1'b0;
            index_q <= '0;
            hit_q   <= 1'b0;
            multi_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            prev_q  <= prev_d;
            for (int i = 0; i < 10; i++) cnt_q[i] <= cnt_d[i];
            start_q <= start_d;
            state_q <= state_d;
            valid_q <= valid_d;
            index_q <= index_d;
            hit_q   <= hit_d;
            multi_q <= multi_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.START_PULSE = start_q;
    assign bus.SW_CLEAN    = deb_q[9:1];
    assign bus.RESP_VALID  = valid_q;
    assign bus.RESP_INDEX  = index_q;
    assign bus.RESP_HIT    = hit_q;
    assign bus.RESP_MULTI  = multi_q;
`ifdef SWRESP_FALSE_START_EN
    assign bus.FALSE_START = fs_q;
`else
    assign bus.FALSE_START = 1'b0;
`endif
endmodule

// File: doc/switch_response_encoder.md
# switch_response_encoder

- Input-side front end of the reaction-timer game, the encoding counterpart of the LED one-hot decoder.
- Synchronizes and debounces KEY0 and SW[9:1], and turns the debounced start key into a one-cycle start event.
- While armed by the game FSM, converts the first switch flip into a registered response: a 4-bit index, a hit/miss against the lit LED, and a multi-flip flag. The game FSM uses this response to stop the BCD counter.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 100000 — consecutive stable clocks required to accept an input change (10 ms at 10 MHz); must be ≥1.

Ports:
- CLK_10MHZ  input  1  system clock; all state on rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- KEY0_RAW  input  1  start push-button, raw, active-low.
- SW_RAW  input  9  switches SW[9:1], raw, active-high (bit 0 = SW1).
- ARM  input  1  level from game FSM; high while the target LED is lit and counting.
- TARGET  input  4  expected switch index 1..9 (same code as ledselect).
- START_PULSE  output  1  one-cycle pulse on debounced KEY0 press.
- SW_CLEAN  output  9  debounced switch levels.
- RESP_VALID  output  1  one-cycle pulse, response captured.
- RESP_INDEX  output  4  index 1..9 of the captured switch; 0 = none.
- RESP_HIT  output  1  RESP_INDEX == TARGET and not multi.
- RESP_MULTI  output  1  more than one switch rose in the capture cycle.
- FALSE_START  output  1  see Configuration.

## Operation
- Each raw input passes through a two-flop synchronizer, then its own debounce counter, width $clog2(DEBOUNCE_CYCLES+1).
- Counter behaviour: clears whenever the synced value equals the debounced value. Otherwise it increments, and on reaching DEBOUNCE_CYCLES the debounced value takes the synced value and the counter clears. Any bounce back restarts the count.
- Edge detect: key_fall = debounced KEY falling; sw_rise[i] = debounced SW[i] rising.
- START_PULSE = registered key_fall, in every state.
- FSM states IDLE, ARMED, DONE:
  - IDLE: ARM high → ARMED.
  - ARMED, ARM low → IDLE, no response.
  - ARMED, any sw_rise → DONE, capture the response, pulse RESP_VALID.
  - DONE: hold the response outputs; ARM low → IDLE and clear the response outputs to 0.
- Capture rules:
  - RESP_INDEX = lowest set index among sw_rise.
  - RESP_MULTI = popcount(sw_rise) > 1.
  - RESP_HIT = (RESP_INDEX == TARGET) && !RESP_MULTI.
  - TARGET outside 1..9 never hits.
- Only rising edges are responses. Falling edges and switches already high are ignored (unless SWRESP_FALSE_START_EN is defined).

## Timing
- Reset values:
  - All outputs 0.
  - Debounced KEY = 1 (released); debounced SW = 0; synchronizer flops at their released levels (KEY 1, SW 0).
  - Counters 0; FSM IDLE.
- Raw change held stable → SW_CLEAN change: 2 + DEBOUNCE_CYCLES clocks.
- SW_CLEAN rise → RESP_VALID: 1 clock. RESP_INDEX, RESP_HIT and RESP_MULTI become valid in the same cycle and are held until ARM falls.
- ARM rising in the same cycle as sw_rise: that edge is not captured, because IDLE→ARMED takes one cycle.
- ARM falling in the same cycle as sw_rise in ARMED: ARM has priority → IDLE, no RESP_VALID.
- RST_N asserted mid-count or in DONE: all state returns immediately to its reset values. Inputs held across reset must re-qualify for the full debounce time.

## Configuration
- SWRESP_FALSE_START_EN defined:
  - In the cycle the FSM enters ARMED, if any SW_CLEAN bit is already 1, go directly to DONE.
  - Pulse RESP_VALID with RESP_INDEX=0, RESP_HIT=0, RESP_MULTI=0, FALSE_START=1.
  - FALSE_START is held until ARM falls.
- Not defined: FALSE_START is tied to 0; switches high at arming are ignored until they fall and rise again.

## Test plan
Sim with DEBOUNCE_CYCLES=4.
- Reset, then glitch SW_RAW[2] high for 3 clocks, then low → SW_CLEAN stays 0 and there is no RESP_VALID.
- KEY0_RAW low for 10 clocks → exactly one START_PULSE, 7 clocks after the fall (2 sync + 4 debounce + 1 register); no pulse on release.
- ARM=1, TARGET=5, SW_RAW[4] (SW5) held high → RESP_VALID one cycle, RESP_INDEX=5, RESP_HIT=1. Outputs hold; then ARM=0 → outputs cleared next clock.
- ARM=1, TARGET=5, SW3 and SW7 rising the same clock → RESP_INDEX=3, RESP_MULTI=1, RESP_HIT=0.
- ARM=1, then ARM=0 in the same cycle as an SW4 rise → FSM IDLE, no RESP_VALID. Also: RST_N pulse low while in DONE → all outputs 0 immediately.
- SW6 high before ARM=1:
  - Macro defined → RESP_VALID 1 clock after arming, FALSE_START=1, RESP_INDEX=0.
  - Macro undefined → no response until SW6 falls and rises again.
